// File: rtl/mult_req_arbiter.sv
// mult_req_arbiter: shares one pipelined WxW multiplier among N_REQ requesters and tags
// each product with its requester ID. Build option MULT_ARB_FIXED_PRIO_EN: fixed priority.
module mult_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 4,
  parameter int LATENCY = 4,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               m_start,
  output logic [W-1:0]       m_a,
  output logic [W-1:0]       m_b,
  input  logic [2*W-1:0]     m_product,
  input  logic               m_valid,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [2*W-1:0]     rsp_product,
  output logic               err_sticky
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  logic [N_REQ-1:0] w_grant;
  logic             w_xfer;
  logic [ID_W-1:0]  w_win_id;
  logic [ID_W-1:0]  w_scan_start;
  logic [W-1:0]     w_op_a;
  logic [W-1:0]     w_op_b;

`ifdef MULT_ARB_FIXED_PRIO_EN
  assign w_scan_start = '0;
`else
  logic [ID_W-1:0] r_last_grant;

  assign w_scan_start = next_id(r_last_grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= LAST_ID;
    end else if (w_xfer) begin
      r_last_grant <= w_win_id;
    end
  end
`endif

  // Walk the requesters once, starting at the scan origin and wrapping at N_REQ.
  always_comb begin
    logic [ID_W-1:0] scan;
    logic            found;
    scan     = w_scan_start;
    found    = 1'b0;
    w_win_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[scan]) begin
        found    = 1'b1;
        w_win_id = scan;
      end
      scan = next_id(scan);
    end
    w_xfer  = found && !reset;
    w_grant = '0;
    if (w_xfer) begin
      w_grant[w_win_id] = 1'b1;
    end
  end

  assign req_ready = w_grant;

  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_win_id == ID_W'(k)) begin
        w_op_a = req_a[k*W +: W];
        w_op_b = req_b[k*W +: W];
      end
    end
  end

  logic            r_start;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [ID_W-1:0] r_issue_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_issue_id <= '0;
    end else begin
      r_start <= w_xfer;
      if (w_xfer) begin
        r_a        <= w_op_a;
        r_b        <= w_op_b;
        r_issue_id <= w_win_id;
      end
    end
  end

  assign m_start = r_start;
  assign m_a     = r_a;
  assign m_b     = r_b;

  // The last stage lines up with the cycle the multiplier should raise m_valid.
  logic [LATENCY-1:0] r_tag_v;
  logic [ID_W-1:0]    r_tag_id [LATENCY];
  logic               w_exp_v;
  logic [ID_W-1:0]    w_exp_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_v <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_tag_id[k] <= '0;
      end
    end else begin
      r_tag_v[0]  <= r_start;
      r_tag_id[0] <= r_issue_id;
      for (int k = 1; k < LATENCY; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  assign w_exp_v  = r_tag_v[LATENCY-1];
  assign w_exp_id = r_tag_id[LATENCY-1];

  logic            r_rsp_valid;
  logic [ID_W-1:0] r_rsp_id;
  logic [2*W-1:0]  r_rsp_product;
  logic            r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_product <= '0;
      r_err         <= 1'b0;
    end else begin
      r_rsp_valid <= w_exp_v;
      r_rsp_id    <= w_exp_id;
      if (w_exp_v) begin
        r_rsp_product <= m_product;
      end
      if (m_valid != w_exp_v) begin
        r_err <= 1'b1;
      end
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_product = r_rsp_product;
  assign err_sticky  = r_err;

endmodule
